// File: rtl/mc_alu_if.sv
// rtl/mc_alu_if.sv - operand/result handshake bundle for the multi-cycle ALU
interface mc_alu_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] f;
    logic             take_branch;
    logic             ovf;
    logic             dbz;

    modport master (
        output in_valid, a, b, s, out_ready,
        input  in_ready, out_valid, f, take_branch, ovf, dbz
    );

    modport slave (
        input  in_valid, a, b, s, out_ready,
        output in_ready, out_valid, f, take_branch, ovf, dbz
    );
endinterface

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU: single-cycle logic ops, iterative shift-add mul and restoring div/rem
module mc_alu #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic      clk,
    input  logic      rst,
    mc_alu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_NOTB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5);
    localparam logic [OPW-1:0] OP_BEQZ = OPW'(6);
    localparam logic [OPW-1:0] OP_BNEZ = OPW'(7);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(8);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(9);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(10);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(11);
    localparam logic [OPW-1:0] OP_REMU = OPW'(12);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [OPW-1:0]   op_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] md_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] f_q;
    logic             ovf_q;
    logic             dbz_q;
    logic             br_q;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] add_r;
    logic [WIDTH-1:0] sub_r;

    logic [WIDTH-1:0] imm_f;
    logic             imm_ovf;
    logic             imm_dbz;
    logic             imm_br;
    logic             imm_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign accept    = bus.in_valid && (state == IDLE);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign add_r     = bus.a + bus.b;
    assign sub_r     = bus.a - bus.b;

    // Results for everything that completes on the accept edge, plus the ITER decision
    always_comb begin
        imm_f    = '0;
        imm_ovf  = 1'b0;
        imm_dbz  = 1'b0;
        imm_br   = 1'b0;
        imm_iter = 1'b0;
        case (bus.s)
            OP_ADD: begin
                imm_f   = add_r;
                imm_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_NOTB: imm_f = ~bus.b;
            OP_AND:  imm_f = bus.a & bus.b;
            OP_OR:   imm_f = bus.a | bus.b;
            OP_SRA:  imm_f = $signed(bus.a) >>> bus.b;
            OP_SLL:  imm_f = bus.a << bus.b;
            OP_BEQZ: imm_br = (bus.a == '0);
            OP_BNEZ: imm_br = (bus.a != '0);
            OP_XOR:  imm_f = bus.a ^ bus.b;
            OP_SUB: begin
                imm_f   = sub_r;
                imm_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_MUL:  imm_iter = 1'b1;
            OP_DIVU: begin
                if (bus.b == '0) begin
                    imm_f   = '1;
                    imm_dbz = 1'b1;
                end else begin
                    imm_iter = 1'b1;
                end
            end
            OP_REMU: begin
                if (bus.b == '0) begin
                    imm_f   = bus.a;
                    imm_dbz = 1'b1;
                end else begin
                    imm_iter = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // hi/lo hold {accumulator, multiplier} for mul and {remainder, dividend/quotient} for div
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    assign div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, md_q};

    always_comb begin
        step_hi = hi_q;
        step_lo = lo_q;
        if (op_q == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = imm_iter ? ITER : DONE;
                end
            end
            ITER: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= '0;
            cnt_q <= '0;
            md_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            f_q   <= '0;
            ovf_q <= 1'b0;
            dbz_q <= 1'b0;
            br_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= bus.s;
                        cnt_q <= '0;
                        md_q  <= (bus.s == OP_MUL) ? bus.a : bus.b;
                        lo_q  <= (bus.s == OP_MUL) ? bus.b : bus.a;
                        hi_q  <= '0;
                        f_q   <= imm_f;
                        ovf_q <= imm_ovf;
                        dbz_q <= imm_dbz;
                        br_q  <= imm_br;
                    end
                end
                ITER: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        f_q   <= (op_q == OP_REMU) ? step_hi : step_lo;
                        ovf_q <= (op_q == OP_MUL) && (step_hi != '0);
                        dbz_q <= 1'b0;
                        br_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.f           = f_q;
    assign bus.ovf         = ovf_q;
    assign bus.dbz         = dbz_q;
    assign bus.take_branch = br_q;
endmodule
